// File: rtl/mem_responder_pkg.sv
// mem_pkg: shared types and constants for the multicycle memory responder.
//   WORD_W      data/address word width
//   MAX_WAIT    largest supported wait-state count
//   CNT_W       width of the wait-state down-counter
//   mem_state_t responder FSM states
//   mem_op_t    latched transaction kind
package mem_pkg;
  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the multicycle
// controller (master) and the memory responder (slave).
//   memread, memwrite  request strobes, held until mem_ready
//   addr, wdata        byte address and write data
//   rdata              registered read data
//   mem_ready          one-cycle completion strobe
//   mem_busy           transaction in flight
//   mem_err            misaligned-access flag, valid with mem_ready
interface mem_responder_if;
  import mem_pkg::*;

  logic              memread;
  logic              memwrite;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              mem_ready;
  logic              mem_busy;
  logic              mem_err;

  modport master (
    output memread, memwrite, addr, wdata,
    input  rdata, mem_ready, mem_busy, mem_err
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output rdata, mem_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/mem_array.sv
// mem_array: word array with synchronous write and registered read.
// No reset: contents and the read register power up undefined.
//   clk        rising-edge clock
//   we/widx/wdata  write enable, word index, data
//   re/ridx    read enable and word index; q updates only when re is high
//   q          registered read word, holds between reads
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     ridx,
  output logic [WORD_W-1:0] q
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) q <= mem[ridx];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory answering memread/memwrite
// after WAIT_CYCLES wait states with a one-cycle mem_ready strobe.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mem_responder_if.slave (request in, rdata/mem_ready/mem_busy/mem_err out)
// Optional feature macro: MEM_MISALIGN_CHK_EN -- flags addr[1:0] != 0 as an
// error, suppressing the write / read update while keeping full latency.
//
// state | meaning
// IDLE  | waiting for memread/memwrite; request latched on the edge leaving
// WAIT  | wait states, counter runs down to 0
// RESP  | mem_ready high for one cycle; write committed on the edge leaving
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  mem_op_t           op;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;
  logic              rd_vld;
  logic [WORD_W-1:0] arr_q;

  logic              req;
  logic              in_err;
  logic [AW-1:0]     in_idx;
  logic              rd_en;
  logic [AW-1:0]     rd_idx;
  logic              wr_en;
  logic              unused_addr;

  assign req    = bus.memread | bus.memwrite;
  assign in_idx = bus.addr[AW+1:2];
  assign unused_addr = ^{bus.addr[WORD_W-1:AW+2], bus.addr[1:0]};

`ifdef MEM_MISALIGN_CHK_EN
  assign in_err = |bus.addr[1:0];
`else
  assign in_err = 1'b0;
`endif

  // The array read fires on the edge entering RESP. With zero wait states
  // that edge is the IDLE sampling edge, so index/op come straight from the bus.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = idx;
    if (state == IDLE && req && WAIT_CYCLES == 0) begin
      rd_en  = !bus.memwrite && !in_err;
      rd_idx = in_idx;
    end else if (state == WAIT && cnt == '0) begin
      rd_en = (op == OP_READ) && !err_q;
    end
  end

  assign wr_en = (state == RESP) && (op == OP_WRITE) && !err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op            <= OP_READ;
      idx           <= '0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      rd_vld        <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_busy  <= 1'b0;
      bus.mem_err   <= 1'b0;
    end else begin
      if (rd_en) rd_vld <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            // write wins when both strobes are high
            op           <= bus.memwrite ? OP_WRITE : OP_READ;
            idx          <= in_idx;
            wdata_q      <= bus.wdata;
            err_q        <= in_err;
            bus.mem_busy <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end else begin
              state         <= RESP;
              bus.mem_ready <= 1'b1;
              bus.mem_err   <= in_err;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state         <= RESP;
            bus.mem_ready <= 1'b1;
            bus.mem_err   <= err_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.mem_ready <= 1'b0;
          bus.mem_busy  <= 1'b0;
          bus.mem_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array read register has no reset; rd_vld masks it to 0 until the first
  // read after reset completes.
  assign bus.rdata = rd_vld ? arr_q : '0;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .widx  (idx),
    .wdata (wdata_q),
    .re    (rd_en),
    .ridx  (rd_idx),
    .q     (arr_q)
  );
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 256;
`ifdef MEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int passed = 0;
  int total  = 0;

  // reference model: word storage per DUT, expected rdata per DUT
  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  logic [31:0] exp_rd [2];
  bit          exp_known [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(bit sel, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    if (sel) begin
      bus2.memread = rd; bus2.memwrite = wr; bus2.addr = a; bus2.wdata = d;
    end else begin
      bus0.memread = rd; bus0.memwrite = wr; bus0.addr = a; bus0.wdata = d;
    end
  endtask

  function automatic logic get_ready(bit sel);
    return sel ? bus2.mem_ready : bus0.mem_ready;
  endfunction
  function automatic logic get_busy(bit sel);
    return sel ? bus2.mem_busy : bus0.mem_busy;
  endfunction
  function automatic logic get_err(bit sel);
    return sel ? bus2.mem_err : bus0.mem_err;
  endfunction
  function automatic logic [31:0] get_rdata(bit sel);
    return sel ? bus2.rdata : bus0.rdata;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // One complete transaction; sel=1 targets the 2-wait DUT, sel=0 the 0-wait DUT.
  task automatic txn(bit sel, bit rd, bit wr, logic [31:0] a, logic [31:0] d, string tag);
    int  w;
    int  k;
    int  busy;
    bit  seen;
    bit  err;
    int  i;
    w = sel ? 2 : 0;
    k = 0; busy = 0; seen = 1'b0;
    @(negedge clk);
    set_req(sel, rd, wr, a, d);
    @(posedge clk);
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (get_busy(sel)) busy++;
      if (get_ready(sel)) seen = 1'b1;
    end
    set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, " latency"}, k, w + 1);
    chk({tag, " busy_cycles"}, busy, w + 1);
    err = CHK && (a[1:0] != 2'b00);
    chk({tag, " mem_err"}, {31'b0, get_err(sel)}, {31'b0, err});
    i = widx(a);
    if (!err) begin
      if (wr) begin
        if (sel) m2[i] = d; else m0[i] = d;
      end else begin
        if (sel ? m2.exists(i) : m0.exists(i)) begin
          exp_rd[sel] = sel ? m2[i] : m0[i];
          exp_known[sel] = 1'b1;
        end else begin
          exp_known[sel] = 1'b0;
        end
      end
    end
    if (exp_known[sel]) chk({tag, " rdata"}, get_rdata(sel), exp_rd[sel]);
    @(negedge clk);
    chk({tag, " ready_strobe_end"}, {31'b0, get_ready(sel)}, 32'h0);
    chk({tag, " busy_end"}, {31'b0, get_busy(sel)}, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          cnt;
    bit          s;
    int          op;

    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'b0, bus2.mem_ready}, 32'h0);
    chk("reset busy",  {31'b0, bus2.mem_busy},  32'h0);
    chk("reset err",   {31'b0, bus2.mem_err},   32'h0);
    chk("reset rdata", bus2.rdata, 32'h0);
    chk("reset rdata w0", bus0.rdata, 32'h0);
    reset = 1'b1;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    exp_known[0] = 1'b1; exp_known[1] = 1'b1;

    // basic read of word 0 with two wait states
    txn(1'b1, 1'b0, 1'b1, 32'h0, $urandom, "wr0");
    txn(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, "rd0");

    // write/read and wrap-around
    txn(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, "rd10");
    txn(1'b1, 1'b1, 1'b0, 32'h10 + 4 * DEPTH, 32'h0, "rd10_wrap");

    // both strobes: write wins, rdata keeps DEADBEEF
    txn(1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, "both20");
    txn(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, "rd20");

    // reset during WAIT of a write aborts it
    txn(1'b1, 1'b0, 1'b1, 32'h30, 32'h11112222, "wr30_old");
    @(negedge clk);
    set_req(1'b1, 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset ready", {31'b0, bus2.mem_ready}, 32'h0);
    chk("midreset busy",  {31'b0, bus2.mem_busy},  32'h0);
    chk("midreset rdata", bus2.rdata, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus2.mem_ready) cnt++;
    end
    chk("midreset no_ready", cnt, 0);
    txn(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, "rd30_after_reset");

    // zero wait states, back-to-back reads with memread held
    txn(1'b0, 1'b0, 1'b1, 32'h0, $urandom, "w0 wr0");
    txn(1'b0, 1'b0, 1'b1, 32'h4, $urandom, "w0 wr4");
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b ready1", {31'b0, bus0.mem_ready}, 32'h1);
    chk("b2b rdata1", bus0.rdata, m0[0]);
    bus0.addr = 32'h4;
    @(negedge clk);
    chk("b2b gap", {31'b0, bus0.mem_ready}, 32'h0);
    @(negedge clk);
    chk("b2b ready2", {31'b0, bus0.mem_ready}, 32'h1);
    chk("b2b rdata2", bus0.rdata, m0[1]);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_rd[0] = m0[1];
    @(negedge clk);
    chk("b2b end", {31'b0, bus0.mem_ready}, 32'h0);

    // misaligned write to 0x42 (behaviour depends on the build)
    txn(1'b1, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, "wr40");
    txn(1'b1, 1'b0, 1'b1, 32'h42, 32'hFFFFFFFF, "wr42");
    txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, "rd40");

    // randomized traffic over a small word window on both DUTs
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom, "fill2");
      txn(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, "fill0");
    end
    for (int i = 0; i < 60; i++) begin
      s  = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 3);
      a  = {$urandom_range(0, 255), 2'b00} * DEPTH;
      a  = a + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d  = $urandom;
      case (op)
        0, 1:    txn(s, 1'b1, 1'b0, a, d, "rnd_rd");
        2:       txn(s, 1'b0, 1'b1, a, d, "rnd_wr");
        default: txn(s, 1'b1, 1'b1, a, d, "rnd_both");
      endcase
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
